// File: rtl/lcd_delay_timer.sv
// Programmable delay timer for LCD sequencing: binary prescaler feeding a tick
// down-counter, with one-shot / periodic modes, retrigger and abort.
module lcd_delay_timer #(
  parameter int unsigned CNT_WIDTH = 20,
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned PS_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 periodic,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] remaining
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [PS_WIDTH-1:0]  PS_LAST = PS_WIDTH'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [0:0]           state_q, state_d;
  logic [PS_WIDTH-1:0]  ps_q, ps_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] reload_val_q, reload_val_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_c;
  logic [CNT_WIDTH-1:0] start_val_c;

  // A zero delay request still runs for one full tick.
  assign start_val_c = (load_val == '0) ? CNT_ONE : load_val;
  assign tick_c      = (ps_q == PS_LAST);

  // Next-state logic; priority is abort > start > tick.
  always_comb begin
    state_d      = state_q;
    ps_d         = ps_q;
    remaining_d  = remaining_q;
    reload_val_d = reload_val_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      remaining_d = '0;
      ps_d        = '0;
    end else if (start) begin
      reload_val_d = start_val_c;
      remaining_d  = start_val_c;
      mode_d       = periodic;
      ps_d         = '0;
      busy_d       = 1'b1;
      state_d      = RUN;
    end else if (state_q == RUN) begin
      ps_d = tick_c ? '0 : ps_q + PS_WIDTH'(1);
      if (tick_c) begin
        if (remaining_q > CNT_ONE) begin
          remaining_d = remaining_q - CNT_ONE;
        end else begin
          done_d = 1'b1;
          if (mode_q) begin
            remaining_d = reload_val_q;
          end else begin
            remaining_d = '0;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
    end else begin
      remaining_d = '0;
      ps_d        = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q      <= IDLE;
      ps_q         <= '0;
      remaining_q  <= '0;
      reload_val_q <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ps_q         <= ps_d;
      remaining_q  <= remaining_d;
      reload_val_q <= reload_val_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_lcd_delay_timer.sv
// Bench for lcd_delay_timer: directed scenarios then random traffic, compared
// against a deadline-based model (start edge + N*PRESCALE arithmetic).
module tb_lcd_delay_timer;

  localparam int unsigned CW = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned PW = 4;

  logic          clock;
  logic          rst;
  logic          start;
  logic          abort;
  logic          periodic;
  logic [CW-1:0] load_val;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  lcd_delay_timer #(.CNT_WIDTH(CW), .PRESCALE(P), .PS_WIDTH(PW)) dut (
    .clock(clock), .rst(rst), .start(start), .abort(abort),
    .periodic(periodic), .load_val(load_val),
    .busy(busy), .done(done), .remaining(remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: timer active flag, edge index of the start, delay and mode.
  int cyc = 0;
  bit m_act = 0;
  int m_t0 = 0;
  int m_n = 0;
  bit m_per = 0;
  int e_rem = 0;
  bit e_done = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit s, input bit a, input bit p, input int lv, input bit r);
    int el;
    int k;
    start = s; abort = a; periodic = p; load_val = CW'(lv); rst = r;
    @(posedge clock);
    cyc++;
    if (!r || a) begin
      m_act = 0; e_done = 0; e_rem = 0;
    end else if (s) begin
      m_act = 1; m_t0 = cyc; m_n = (lv == 0) ? 1 : lv; m_per = p;
      e_rem = m_n; e_done = 0;
    end else if (m_act) begin
      el = cyc - m_t0;
      k  = el / P;
      if (m_per) begin
        e_done = (el % (m_n * P) == 0);
        e_rem  = m_n - (k % m_n);
      end else if (el == m_n * P) begin
        e_done = 1; e_rem = 0; m_act = 0;
      end else begin
        e_done = 0; e_rem = m_n - k;
      end
    end else begin
      e_done = 0; e_rem = 0;
    end
    #1;
    check_eq("busy", int'(busy), int'(m_act));
    check_eq("done", int'(done), int'(e_done));
    check_eq("remaining", int'(remaining), e_rem);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    start = 0; abort = 0; periodic = 0; load_val = '0; rst = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    idle(2);

    // One-shot N=3: remaining 3,2,1,0, a single done, busy for 12 cycles.
    done_cnt = 0; busy_cnt = 0;
    step(1, 0, 0, 3, 1);
    check_eq("os_rem_e0", int'(remaining), 3);
    idle(3);
    step(0, 0, 0, 0, 1);
    check_eq("os_rem_e4", int'(remaining), 2);
    idle(7);
    step(0, 0, 0, 0, 1);
    check_eq("os_done_e12", int'(done), 1);
    check_eq("os_rem_e12", int'(remaining), 0);
    idle(4);
    check_eq("os_done_cnt", done_cnt, 1);
    check_eq("os_busy_cycles", busy_cnt, 12);

    // Periodic N=2: done after E8/E16/E24, abort at E26 stops it.
    done_cnt = 0; busy_cnt = 0;
    step(1, 0, 1, 2, 1);
    idle(25);
    check_eq("per_done_cnt", done_cnt, 3);
    check_eq("per_busy_cycles", busy_cnt, 26);
    step(0, 1, 0, 0, 1);
    check_eq("per_abort_busy", int'(busy), 0);
    idle(12);
    check_eq("per_after_abort_done", done_cnt, 3);

    // Retrigger at E10 with N'=2: one done after E18 only.
    done_cnt = 0;
    step(1, 0, 0, 5, 1);
    idle(9);
    step(1, 0, 0, 2, 1);
    idle(12);
    check_eq("retrig_done_cnt", done_cnt, 1);

    // Abort on the expiry edge suppresses done.
    done_cnt = 0;
    step(1, 0, 0, 3, 1);
    idle(11);
    step(0, 1, 0, 0, 1);
    idle(4);
    check_eq("abort_expiry_done_cnt", done_cnt, 0);

    // Abort together with start leaves the timer idle.
    step(1, 1, 0, 3, 1);
    check_eq("abort_start_busy", int'(busy), 0);
    idle(3);

    // load_val=0 behaves as one tick.
    done_cnt = 0;
    step(1, 0, 0, 0, 1);
    idle(3);
    step(0, 0, 0, 0, 1);
    check_eq("zero_load_done_e4", int'(done), 1);
    idle(4);
    check_eq("zero_load_done_cnt", done_cnt, 1);

    // Reset at E6 of an N=3 run: never any done for it.
    done_cnt = 0;
    step(1, 0, 0, 3, 1);
    idle(5);
    step(0, 0, 0, 0, 0);
    idle(12);
    check_eq("rst_mid_done_cnt", done_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(15) == 0), ($urandom_range(63) == 0),
           1'($urandom_range(1)), int'($urandom_range(7)),
           ($urandom_range(255) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
